// File: rtl/arb_pkg.sv
// Shared types and helpers for the shared-unit round-robin arbiter.
// Index signals are sized for the largest supported requester count.
package arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned CNT_W   = $clog2(16);
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     pos;

  // Rotate so bit 0 is the requester the pointer names.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    pos   = '0;
    // Scan downwards so the lowest rotated position is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        pos   = {1'b0, ptr} + (IDX_W + 1)'(k);
      end
    end
    if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
      pos = pos - (IDX_W + 1)'(NUM_REQ);
    end
    idx    = pos[IDX_W-1:0];
    onehot = valid ? NUM_REQ'(idx_to_onehot(idx)) : '0;
  end

endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin front end that time-shares one two-operand unit among NUM_REQ requesters.
// Operands are registered on the grant edge; the result returns after UNIT_LAT edges.
module shared_unit_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned UNIT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_in0,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  output logic [DATA_W-1:0]         unit_in0,
  output logic [DATA_W-1:0]         unit_in1,
  input  logic [DATA_W-1:0]         unit_out,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      busy
);

  if (UNIT_LAT < 1 || UNIT_LAT > 15) begin : g_bad_lat
    $error("shared_unit_arbiter: UNIT_LAT must be within 1..15");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_req
    $error("shared_unit_arbiter: NUM_REQ must be within 2..8");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(UNIT_LAT);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    rsp_q, rsp_d;
  logic [DATA_W-1:0]    in0_q, in0_d;
  logic [DATA_W-1:0]    in1_q, in1_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [DATA_W-1:0]    win_in0, win_in1;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    win_in0 = '0;
    win_in1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        win_in0 = req_in0[i*DATA_W +: DATA_W];
        win_in1 = req_in1[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    rsp_d   = rsp_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          grant_d = pick_oh;
          in0_d   = win_in0;
          in1_d   = win_in1;
          cnt_d   = LAT_INIT;
          ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
          rsp_d   = unit_out;
          ack_d   = grant_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        // Requests are ignored here so an acked requester has an edge to drop req.
        state_d = StIdle;
        ack_d   = '0;
        grant_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rsp_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
    end
  end

  assign unit_in0 = in0_q;
  assign unit_in1 = in1_q;
  assign grant    = grant_q;
  assign ack      = ack_q;
  assign rsp_out  = rsp_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Scoreboard bench for shared_unit_arbiter: a timeline model predicts grants and results,
// a separate monitor compares every cycle and pops expectations when ack appears.
module tb_shared_unit_arbiter;

  localparam int N   = 4;
  localparam int DW  = 2;
  localparam int LAT = 3;
  localparam int BW  = N * DW;

  typedef struct {
    int            who;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            e0;
  } txn_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic [N-1:0]  req     = '0;
  logic [BW-1:0] req_in0 = '0;
  logic [BW-1:0] req_in1 = '0;
  logic [DW-1:0] noise   = '0;
  logic [DW-1:0] unit_in0, unit_in1, unit_out, rsp_out;
  logic [N-1:0]  grant, ack;
  logic          busy;

  int   total = 0;
  int   bad   = 0;
  int   stim_timeouts = 0;

  // Reference model state: transactions serialise, each occupying LAT+2 edges.
  int   cyc = 0;
  int   next_free = 0;
  int   ptr_m = 0;
  int   w, j;
  bit   cur_valid = 1'b0;
  txn_t cur;
  txn_t sb[$];

  // Unit model: XOR of the operands, perturbed per cycle so the sampling edge matters.
  assign unit_out = unit_in0 ^ unit_in1 ^ noise;

  always #5 clk = ~clk;

  shared_unit_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .UNIT_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_in0  (req_in0),
    .req_in1  (req_in1),
    .unit_in0 (unit_in0),
    .unit_in1 (unit_in1),
    .unit_out (unit_out),
    .grant    (grant),
    .ack      (ack),
    .rsp_out  (rsp_out),
    .busy     (busy)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      cur_valid = 1'b0;
      ptr_m     = 0;
      next_free = 0;
    end else begin
      cyc++;
      if (cur_valid && cyc > cur.e0 + LAT) cur_valid = 1'b0;
      if (cyc >= next_free && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (w < 0 && req[j]) w = j;
        end
        cur.who = w;
        cur.a   = req_in0[w*DW +: DW];
        cur.b   = req_in1[w*DW +: DW];
        cur.e0  = cyc;
        sb.push_back(cur);
        cur_valid = 1'b1;
        ptr_m     = (w + 1) % N;
        next_free = cyc + LAT + 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial begin : monitor
    logic [N-1:0] exp_grant;
    int           seen_to;
    txn_t         t;
    seen_to = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", rsp_out, 0);
        chk("rst_unit_in0", unit_in0, 0);
        chk("rst_unit_in1", unit_in1, 0);
      end else begin
        exp_grant = cur_valid ? (N'(1) << cur.who) : '0;
        chk("grant", grant, exp_grant);
        chk("busy", busy, cur_valid);
        chk("ack_onehot0", $onehot0(ack), 1);
        if (cur_valid) begin
          chk("unit_in0", unit_in0, cur.a);
          chk("unit_in1", unit_in1, cur.b);
        end
        if (ack != '0 || (cur_valid && cyc == cur.e0 + LAT)) begin
          if (sb.size() == 0) begin
            chk("ack_unexpected", ack, 0);
          end else begin
            t = sb.pop_front();
            chk("ack_who", ack, N'(1) << t.who);
            chk("ack_cycle", cyc, t.e0 + LAT);
            chk("rsp_out", rsp_out, t.a ^ t.b ^ noise);
          end
        end
        chk("wait_bound", stim_timeouts, seen_to);
        seen_to = stim_timeouts;
      end
    end
  end

  task automatic run(input int n, input int p_raise, input bit chaos);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (chaos && grant[i] && $urandom_range(7) == 0) begin
          req[i] = 1'b0;
        end else if (chaos && grant[i] && $urandom_range(3) == 0) begin
          req_in0[i*DW +: DW] = DW'($urandom);
          req_in1[i*DW +: DW] = DW'($urandom);
        end else if (!req[i] && !grant[i] && $urandom_range(99) < p_raise) begin
          req_in0[i*DW +: DW] = DW'($urandom);
          req_in1[i*DW +: DW] = DW'($urandom);
          req[i] = 1'b1;
        end
      end
      noise = chaos ? DW'($urandom) : '0;
    end
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) stim_timeouts++;
  endtask

  initial begin : stim
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req     = N'($urandom);
      req_in0 = BW'($urandom);
      req_in1 = BW'($urandom);
      noise   = DW'($urandom);
    end
    @(negedge clk);
    req   = N'($urandom_range(1, (1 << N) - 1));
    noise = '0;
    rst_n = 1'b1;
    run(30, 0, 1'b0);

    // Lone requester 2 with operands 01 and 10.
    req_in0[2*DW +: DW] = 2'b01;
    req_in1[2*DW +: DW] = 2'b10;
    req = 4'b0100;
    run(10, 0, 1'b0);

    // Reset while requester 1 owns the unit; afterwards the pointer restarts at 0.
    req_in0 = BW'($urandom);
    req_in1 = BW'($urandom);
    req = 4'b0010;
    wait_busy();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req   = 4'b1010;
    rst_n = 1'b1;
    run(20, 0, 1'b0);

    // Owner 1 drops req mid-transaction while 0 and 3 wait with the pointer at 2.
    req_in0 = BW'($urandom);
    req_in1 = BW'($urandom);
    req = 4'b0010;
    wait_busy();
    req = 4'b1001;
    run(25, 0, 1'b0);

    // Everyone requesting continuously.
    req_in0 = BW'($urandom);
    req_in1 = BW'($urandom);
    req = '1;
    run(45, 100, 1'b0);

    run(3000, 25, 1'b1);
    req = '0;
    run(10, 0, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
